// File: rtl/akash_driver_v1_if.sv
// Hall inputs, drive controls and gate outputs of the six-step commutation driver.
// master = controller/bench side, slave = driver side.
interface akash_driver_v1_if;
    logic H_1;
    logic H_2;
    logic H_3;
    logic en;
    logic dir;
    logic A;
    logic B;
    logic C;
    logic Ad;
    logic Bd;
    logic Cd;
    logic fault;

    modport master (
        output H_1, H_2, H_3, en, dir,
        input  A, B, C, Ad, Bd, Cd, fault
    );

    modport slave (
        input  H_1, H_2, H_3, en, dir,
        output A, B, C, Ad, Bd, Cd, fault
    );
endinterface

// File: rtl/akash_driver_v1.sv
// Six-step BLDC commutation: Hall sync + deglitch, commutation table, per-gate dead-time.
// Gate vectors are ordered {A, B, C, Ad, Bd, Cd}.
module akash_driver_v1 #(
    parameter int FILT_CYCLES = 4,
    parameter int DEAD_CYCLES = 8
) (
    input logic clk,
    input logic rst_n,
    akash_driver_v1_if.slave bus
);
    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_CYCLES);
    localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_CYCLES);

    logic [2:0]    sync1_q, sync2_q, last_q;
    logic [2:0]    hall_filt_q, hall_filt_d;
    logic [FW-1:0] held_q, held_d;
    logic          fault_q, fault_d;
    logic [5:0]    want, opp_q;
    logic [5:0]    gate_q, gate_d;
    logic [DW-1:0] cnt_q [6];
    logic [DW-1:0] cnt_d [6];

    // Forward table as one-hot {A,B,C} high / low; reverse swaps the two roles.
    function automatic logic [5:0] commutate(input logic [2:0] h, input logic rev);
        logic [2:0] hi;
        logic [2:0] lo;
        hi = 3'b000;
        lo = 3'b000;
        case (h)
            3'b100: begin hi = 3'b100; lo = 3'b010; end
            3'b101: begin hi = 3'b100; lo = 3'b001; end
            3'b001: begin hi = 3'b010; lo = 3'b001; end
            3'b011: begin hi = 3'b010; lo = 3'b100; end
            3'b010: begin hi = 3'b001; lo = 3'b100; end
            3'b110: begin hi = 3'b001; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        return rev ? {lo, hi} : {hi, lo};
    endfunction

    // held_q counts consecutive clocks the synchronised code has differed from hall_filt.
    always_comb begin
        held_d      = held_q;
        hall_filt_d = hall_filt_q;
        if (sync2_q == hall_filt_q) begin
            held_d = '0;
        end else begin
            if (sync2_q != last_q) begin
                held_d = FW'(1);
            end else if (held_q != FILT_MAX) begin
                held_d = held_q + FW'(1);
            end
            if (held_d == FILT_MAX) begin
                hall_filt_d = sync2_q;
                held_d      = '0;
            end
        end
        fault_d = (hall_filt_d == 3'b000) || (hall_filt_d == 3'b111);
    end

    assign want  = (bus.en && !fault_q) ? commutate(hall_filt_q, bus.dir) : 6'b000000;
    assign opp_q = {gate_q[2:0], gate_q[5:3]};

    // A gate only counts while its same-phase partner is off, so turn-on always trails the partner's turn-off.
    always_comb begin
        gate_d = gate_q;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!want[i]) begin
                cnt_d[i]  = '0;
                gate_d[i] = 1'b0;
            end else if (opp_q[i]) begin
                cnt_d[i] = '0;
            end else if (!gate_q[i]) begin
                cnt_d[i]  = cnt_q[i] + DW'(1);
                gate_d[i] = (cnt_d[i] == DEAD_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            last_q      <= '0;
            held_q      <= '0;
            hall_filt_q <= '0;
            fault_q     <= 1'b1;
            gate_q      <= '0;
            for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q     <= {bus.H_1, bus.H_2, bus.H_3};
            sync2_q     <= sync1_q;
            last_q      <= sync2_q;
            held_q      <= held_d;
            hall_filt_q <= hall_filt_d;
            fault_q     <= fault_d;
            gate_q      <= gate_d;
            for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.A     = gate_q[5];
    assign bus.B     = gate_q[4];
    assign bus.C     = gate_q[3];
    assign bus.Ad    = gate_q[2];
    assign bus.Bd    = gate_q[1];
    assign bus.Cd    = gate_q[0];
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_akash_driver_v1.sv
// Directed bench for akash_driver_v1: settled-state vector table plus timing/corner sequences.
module tb_akash_driver_v1;
  localparam int F = 4;
  localparam int D = 8;
  localparam int HOLD = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  akash_driver_v1_if bus ();

  akash_driver_v1 #(.FILT_CYCLES(F), .DEAD_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] h;
    logic       en;
    logic       dir;
    logic [5:0] gates;
    logic       fault;
  } vec_t;

  typedef struct {
    logic [2:0] h;
    int         on_idx;
    int         off_idx;
    logic [5:0] gates;
  } step_t;

  function automatic logic [5:0] gates();
    return {bus.A, bus.B, bus.C, bus.Ad, bus.Bd, bus.Cd};
  endfunction

  task automatic set_h(input logic [2:0] h);
    {bus.H_1, bus.H_2, bus.H_3} = h;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got gates/fault=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shoot-through guard on every clock while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((bus.A && bus.Ad) || (bus.B && bus.Bd) || (bus.C && bus.Cd)) begin
        bad++;
        $display("FAIL shoot_through: got gates=%b expected no phase with both on", gates());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt[14];
    step_t sw[6];
    int on_lag, off_lag, off_run, bd_seen_low;
    logic stable_ok;

    vt[0]  = '{3'b100, 1'b1, 1'b0, 6'b100010, 1'b0};
    vt[1]  = '{3'b101, 1'b1, 1'b0, 6'b100001, 1'b0};
    vt[2]  = '{3'b001, 1'b1, 1'b0, 6'b010001, 1'b0};
    vt[3]  = '{3'b011, 1'b1, 1'b0, 6'b010100, 1'b0};
    vt[4]  = '{3'b010, 1'b1, 1'b0, 6'b001100, 1'b0};
    vt[5]  = '{3'b110, 1'b1, 1'b0, 6'b001010, 1'b0};
    vt[6]  = '{3'b110, 1'b1, 1'b1, 6'b010001, 1'b0};
    vt[7]  = '{3'b100, 1'b1, 1'b1, 6'b010100, 1'b0};
    vt[8]  = '{3'b111, 1'b1, 1'b0, 6'b000000, 1'b1};
    vt[9]  = '{3'b000, 1'b1, 1'b0, 6'b000000, 1'b1};
    vt[10] = '{3'b011, 1'b1, 1'b0, 6'b010100, 1'b0};
    vt[11] = '{3'b011, 1'b0, 1'b0, 6'b000000, 1'b0};
    vt[12] = '{3'b010, 1'b0, 1'b1, 6'b000000, 1'b0};
    vt[13] = '{3'b010, 1'b1, 1'b1, 6'b100001, 1'b0};

    // Gate bit index: A=5 B=4 C=3 Ad=2 Bd=1 Cd=0.
    sw[0] = '{3'b100, 5, 3, 6'b100010};
    sw[1] = '{3'b101, 0, 1, 6'b100001};
    sw[2] = '{3'b001, 4, 5, 6'b010001};
    sw[3] = '{3'b011, 2, 0, 6'b010100};
    sw[4] = '{3'b010, 3, 4, 6'b001100};
    sw[5] = '{3'b110, 1, 2, 6'b001010};

    // Reset with an arbitrary Hall code, then release on 000.
    bus.en = 1'b0;
    bus.dir = 1'b0;
    set_h(3'($urandom_range(7, 0)));
    tick(3);
    check("reset_state", {gates(), bus.fault}, 7'b000000_1);
    set_h(3'b000);
    bus.en = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(30);
    check("release_000", {gates(), bus.fault}, 7'b000000_1);

    // Settled-state table.
    for (int i = 0; i < 14; i++) begin
      set_h(vt[i].h);
      bus.en = vt[i].en;
      bus.dir = vt[i].dir;
      tick(HOLD);
      check($sformatf("vec%0d_h%b_en%b_dir%b", i, vt[i].h, vt[i].en, vt[i].dir),
            {gates(), bus.fault}, {vt[i].gates, vt[i].fault});
    end

    // Forward sweep with edge latency, starting from a settled 110.
    bus.en = 1'b1;
    bus.dir = 1'b0;
    set_h(3'b110);
    tick(HOLD);
    for (int s = 0; s < 6; s++) begin
      set_h(sw[s].h);
      on_lag = -1;
      off_lag = -1;
      for (int k = 1; k <= 100; k++) begin
        tick(1);
        if (on_lag < 0 && gates()[sw[s].on_idx]) on_lag = k;
        if (off_lag < 0 && !gates()[sw[s].off_idx]) off_lag = k;
      end
      check_cond($sformatf("sweep%0d_on_lag", s),
                 on_lag >= 2 + F + D && on_lag <= 2 + F + 1 + D, on_lag, 2 + F + 1 + D);
      check_cond($sformatf("sweep%0d_off_lag", s), off_lag == 2 + F + 1, off_lag, 2 + F + 1);
      check($sformatf("sweep%0d_pair", s), {gates(), bus.fault}, {sw[s].gates, 1'b0});
    end

    // Glitch shorter than the filter window is ignored.
    set_h(3'b100);
    tick(HOLD);
    set_h(3'b101);
    tick(F - 1);
    set_h(3'b100);
    stable_ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (gates() !== 6'b100010 || bus.fault !== 1'b0) stable_ok = 1'b0;
    end
    check_cond("glitch_ignored", stable_ok, int'(stable_ok), 1);

    // A pulse exactly as long as the window is accepted (Bd must drop at some point).
    set_h(3'b101);
    tick(F);
    set_h(3'b100);
    bd_seen_low = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (!bus.Bd) bd_seen_low = 1;
    end
    check_cond("pulse_accepted", bd_seen_low == 1, bd_seen_low, 1);
    tick(HOLD);
    check("after_pulse", {gates(), bus.fault}, 7'b100010_0);

    // Dead-time 011 -> 110: B off for at least D clocks before Bd on.
    set_h(3'b011);
    tick(HOLD);
    set_h(3'b110);
    off_run = 0;
    on_lag = -1;
    for (int k = 1; k <= HOLD; k++) begin
      tick(1);
      if (on_lag < 0) begin
        if (bus.Bd) on_lag = k;
        else if (!bus.B) off_run++;
      end
    end
    check_cond("deadtime_bd_seen", on_lag > 0, on_lag, 2 + F + 1 + D);
    check_cond("deadtime_b_off_run", off_run >= D, off_run, D);
    check("deadtime_final", {gates(), bus.fault}, 7'b001010_0);

    // en falling together with a Hall change: everything off one clock later.
    set_h(3'b100);
    bus.en = 1'b0;
    tick(1);
    check("en_off_1clk", {gates(), bus.fault}, 7'b000000_0);
    tick(HOLD);
    check("en_off_hold", {gates(), bus.fault}, 7'b000000_0);

    // Reverse on 100 -> B / Ad after the dead-time.
    bus.dir = 1'b1;
    bus.en = 1'b1;
    tick(D - 1);
    check("rev_before_dead", {gates(), bus.fault}, 7'b000000_0);
    tick(2);
    check("rev_100", {gates(), bus.fault}, 7'b010100_0);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {gates(), bus.fault}, 7'b000000_1);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
